traffic_input_conditioner: RTL and testbench

- Upstream front end for the traffic light controller. Takes raw asynchronous pedestrian-button and car-loop signals and produces the controller's `pedestrian_button` and `car_sensor` inputs.
- Synchronises, debounces and latches the pedestrian request until the controller has served it, which it sees on the fed-back `lights` bus.
- Flags a stuck pedestrian button.

---
 rtl/traffic_pkg.sv | 16 +
 rtl/traffic_input_conditioner_if.sv | 29 ++
 rtl/sync_debounce.sv | 44 ++++
 rtl/traffic_input_conditioner.sv | 107 ++++++++++
 tb/tb_traffic_input_conditioner.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared light encodings and pedestrian FSM states
// Purpose: constants shared by the traffic input conditioner files.
// Ports: none (package).
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b100;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PENDING = 2'b01,
    HOLDOFF = 2'b10
  } ped_state_t;

endpackage

// File: rtl/traffic_input_conditioner_if.sv
// rtl/traffic_input_conditioner_if.sv - signal bundle between raw inputs, controller and conditioner
// Purpose: groups the raw pins, lights feedback and conditioned outputs.
// Ports (signals):
//   ped_btn_raw, car_raw : raw asynchronous inputs
//   lights_in[2:0]       : controller lights feedback, one-hot
//   ped_req, car_present, ped_press, ped_stuck, served_pulse : conditioned outputs
// Modports: slave = conditioner side, master = environment side.
interface traffic_input_conditioner_if;

  logic       ped_btn_raw;
  logic       car_raw;
  logic [2:0] lights_in;
  logic       ped_req;
  logic       car_present;
  logic       ped_press;
  logic       ped_stuck;
  logic       served_pulse;

  modport slave (
    input  ped_btn_raw, car_raw, lights_in,
    output ped_req, car_present, ped_press, ped_stuck, served_pulse
  );

  modport master (
    output ped_btn_raw, car_raw, lights_in,
    input  ped_req, car_present, ped_press, ped_stuck, served_pulse
  );

endinterface

// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - two-flop synchroniser followed by a debounce counter
// Purpose: brings one asynchronous pin into the clk domain and filters bounces.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   raw   : asynchronous input pin
//   db    : debounced value, flips after DEBOUNCE_CYCLES consecutive differing samples
module sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      db    <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        // This would be the DEBOUNCE_CYCLES-th differing sample: accept it.
        db  <= ~db;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/traffic_input_conditioner.sv
// rtl/traffic_input_conditioner.sv - conditions button/loop inputs for the traffic light controller
// Purpose: debounces both raw inputs, latches the pedestrian request until the
//          controller serves it (RED entry on lights_in), flags a stuck button.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : traffic_input_conditioner_if.slave (raw pins, lights feedback, outputs)
module traffic_input_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int STUCK_CYCLES    = 64
) (
  input logic                          clk,
  input logic                          reset,
  traffic_input_conditioner_if.slave   bus
);

  localparam int SW = $clog2(STUCK_CYCLES + 1);

  logic          btn_db;
  logic          car_db;
  logic          btn_db_q;
  logic [2:0]    lights_q;
  logic [SW-1:0] stuck_cnt;
  ped_state_t    state;
  ped_state_t    state_next;
  logic          red_entry;
  logic          btn_rise;
  logic          press_ok;
  logic          serve;
  logic          ped_req_q;
  logic          car_present_q;
  logic          ped_press_q;
  logic          ped_stuck_q;
  logic          served_q;

  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.ped_btn_raw),
    .db    (btn_db)
  );

  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_car (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.car_raw),
    .db    (car_db)
  );

  // Only a genuine one-hot RED counts; invalid codes and 000 are "not RED".
  assign red_entry = (bus.lights_in == LIGHT_RED) && (lights_q != LIGHT_RED);
  assign btn_rise  = btn_db & ~btn_db_q;
  assign press_ok  = btn_rise && !ped_stuck_q && ((state == IDLE) || (state == PENDING));

  // The FSM consumes the registered press pulse, so ped_req follows ped_press by one cycle.
  always_comb begin
    state_next = state;
    serve      = 1'b0;
    case (state)
      IDLE:    if (ped_press_q) state_next = PENDING;
      PENDING: if (red_entry) begin
        state_next = HOLDOFF;
        serve      = 1'b1;
      end
      HOLDOFF: if (bus.lights_in != LIGHT_RED) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      btn_db_q      <= 1'b0;
      lights_q      <= 3'b000;
      stuck_cnt     <= '0;
      ped_req_q     <= 1'b0;
      car_present_q <= 1'b0;
      ped_press_q   <= 1'b0;
      ped_stuck_q   <= 1'b0;
      served_q      <= 1'b0;
    end else begin
      state         <= state_next;
      btn_db_q      <= btn_db;
      lights_q      <= bus.lights_in;
      ped_req_q     <= (state_next == PENDING);
      car_present_q <= car_db;
      ped_press_q   <= press_ok;
      served_q      <= serve;
      if (!btn_db) begin
        stuck_cnt   <= '0;
        ped_stuck_q <= 1'b0;
      end else if (stuck_cnt != SW'(STUCK_CYCLES)) begin
        stuck_cnt <= stuck_cnt + SW'(1);
        if (stuck_cnt == SW'(STUCK_CYCLES - 1)) ped_stuck_q <= 1'b1;
      end
    end
  end

  assign bus.ped_req      = ped_req_q;
  assign bus.car_present  = car_present_q;
  assign bus.ped_press    = ped_press_q;
  assign bus.ped_stuck    = ped_stuck_q;
  assign bus.served_pulse = served_q;

endmodule

// File: tb/tb_traffic_input_conditioner.sv
// tb/tb_traffic_input_conditioner.sv - directed self-checking bench for traffic_input_conditioner
// Purpose: drives raw pins and lights feedback through the interface and checks outputs.
// Ports: none (top-level bench).
module tb_traffic_input_conditioner;
  import traffic_pkg::*;

  logic clk;
  logic reset;
  int   tests;
  int   failed;
  int   cnt;

  traffic_input_conditioner_if bus ();

  traffic_input_conditioner #(.DEBOUNCE_CYCLES(8), .STUCK_CYCLES(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    reset = 1'b1;
    bus.ped_btn_raw = 1'b0;
    bus.car_raw = 1'b0;
    bus.lights_in = LIGHT_GREEN;
    step(3);
    check("rst_ped_req", bus.ped_req, 0);
    check("rst_car_present", bus.car_present, 0);
    check("rst_ped_press", bus.ped_press, 0);
    check("rst_ped_stuck", bus.ped_stuck, 0);
    check("rst_served", bus.served_pulse, 0);
    reset = 1'b0;
    step(2);

    // Glitch: 3-cycle pulse must not get through an 8-cycle debouncer.
    bus.ped_btn_raw = 1'b1;
    step(3);
    bus.ped_btn_raw = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.ped_press) cnt++;
    end
    check("glitch_press_count", cnt, 0);
    check("glitch_ped_req", bus.ped_req, 0);

    // Clean press with GREEN: press pulse 11 edges after pin change, req one later.
    bus.ped_btn_raw = 1'b1;
    step(10);
    check("press_early", bus.ped_press, 0);
    step(1);
    check("press_pulse", bus.ped_press, 1);
    check("press_req_before", bus.ped_req, 0);
    step(1);
    check("press_pulse_end", bus.ped_press, 0);
    check("press_req_set", bus.ped_req, 1);
    step(8);
    bus.ped_btn_raw = 1'b0;
    step(14);
    check("req_latched", bus.ped_req, 1);

    // GREEN -> RED serves the request.
    bus.lights_in = LIGHT_RED;
    step(1);
    check("serve_pulse", bus.served_pulse, 1);
    check("serve_req_clear", bus.ped_req, 0);
    step(1);
    check("serve_pulse_end", bus.served_pulse, 0);

    // Press while still RED (HOLDOFF) is ignored.
    bus.ped_btn_raw = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.ped_press || bus.ped_req) cnt++;
    end
    bus.ped_btn_raw = 1'b0;
    step(14);
    check("holdoff_ignored", cnt, 0);

    // YELLOW returns to IDLE; next press accepted.
    bus.lights_in = LIGHT_YELLOW;
    step(1);
    bus.ped_btn_raw = 1'b1;
    step(11);
    check("second_press_pulse", bus.ped_press, 1);
    step(1);
    check("second_press_req", bus.ped_req, 1);
    bus.ped_btn_raw = 1'b0;
    step(14);

    // Simultaneous debounced rise and GREEN->RED while PENDING: serve wins.
    bus.lights_in = LIGHT_GREEN;
    step(2);
    bus.ped_btn_raw = 1'b1;
    step(10);
    bus.lights_in = LIGHT_RED;
    step(1);
    check("simul_served", bus.served_pulse, 1);
    check("simul_req", bus.ped_req, 0);
    check("simul_press", bus.ped_press, 1);
    check("simul_state", dut.state, HOLDOFF);
    step(1);
    check("simul_req_after", bus.ped_req, 0);
    bus.ped_btn_raw = 1'b0;
    step(14);
    check("simul_req_settled", bus.ped_req, 0);

    // Car path: rises/falls 11 edges after the pin change.
    bus.car_raw = 1'b1;
    step(10);
    check("car_rise_early", bus.car_present, 0);
    step(1);
    check("car_rise", bus.car_present, 1);
    step(19);
    bus.car_raw = 1'b0;
    step(10);
    check("car_fall_early", bus.car_present, 1);
    step(1);
    check("car_fall", bus.car_present, 0);

    // Toggling every 4 cycles never reaches the debounce threshold.
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if ((i % 4) == 0) bus.car_raw = ~bus.car_raw;
      step(1);
      if (bus.car_present) cnt++;
    end
    bus.car_raw = 1'b0;
    step(12);
    check("car_toggle_stable", cnt, 0);

    // Stuck button: held 100 cycles from IDLE.
    bus.lights_in = LIGHT_GREEN;
    step(2);
    bus.ped_btn_raw = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      step(1);
      if (bus.ped_press) cnt++;
      if (i == 73) check("stuck_before", bus.ped_stuck, 0);
      if (i == 74) check("stuck_set", bus.ped_stuck, 1);
    end
    check("stuck_one_press", cnt, 1);
    bus.ped_btn_raw = 1'b0;
    step(11);
    check("stuck_cleared", bus.ped_stuck, 0);
    step(3);
    bus.ped_btn_raw = 1'b1;
    step(11);
    check("after_stuck_press", bus.ped_press, 1);
    check("after_stuck_req", bus.ped_req, 1);

    // Build up car_present and ped_stuck, then reset asynchronously mid-cycle.
    bus.car_raw = 1'b1;
    step(80);
    check("pre_reset_stuck", bus.ped_stuck, 1);
    check("pre_reset_car", bus.car_present, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_req", bus.ped_req, 0);
    check("async_rst_car", bus.car_present, 0);
    check("async_rst_stuck", bus.ped_stuck, 0);
    bus.ped_btn_raw = 1'b0;
    bus.car_raw = 1'b0;
    step(2);
    reset = 1'b0;
    bus.lights_in = 3'b011;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) bus.lights_in = 3'b000;
      if (i == 20) bus.lights_in = 3'b011;
      step(1);
      if (bus.ped_req || bus.car_present || bus.ped_press || bus.ped_stuck || bus.served_pulse) cnt++;
    end
    check("post_reset_quiet", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
